// File: rtl/rf_scb.sv
// Register file with a per-register busy scoreboard; reads are combinational (zero latency).
// Issue requests are refused via issue_ok while the target is busy; the requester retries.
module rf_scb #(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    read1regsel,
    input  logic [AW-1:0]    read2regsel,
    output logic [WIDTH-1:0] read1data,
    output logic [WIDTH-1:0] read2data,
    output logic             read1busy,
    output logic             read2busy,
    input  logic [AW-1:0]    writeregsel,
    input  logic [WIDTH-1:0] writedata,
    input  logic             write,
    input  logic             issue,
    input  logic [AW-1:0]    issueregsel,
    output logic             issue_ok,
    output logic [AW:0]      busycount
);
    localparam int NREGS = 2**AW;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic wr_en;
    logic issue_zero;
    logic issue_set;
    logic wr_clears;

    // Writes and issues aimed at a hardwired-zero r0 are dropped here, so r0 stays 0 and idle.
    assign wr_en      = write && !((ZERO_REG != 0) && (writeregsel == '0));
    assign issue_zero = (ZERO_REG != 0) && (issueregsel == '0);

    always_comb begin
        issue_ok = 1'b1;
        if (!issue_zero) begin
            issue_ok = !busy_q[issueregsel] || (write && (writeregsel == issueregsel));
        end
    end

    assign issue_set = issue && issue_ok && !issue_zero;
    // A same-cycle issue to the written register wins, so the write does not clear busy.
    assign wr_clears = wr_en && !(issue_set && (issueregsel == writeregsel));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[writeregsel] = writedata;
            busy_d[writeregsel] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issueregsel] = 1'b1;
        end
    end

    always_comb begin
        read1data = regs_q[read1regsel];
        read1busy = busy_q[read1regsel];
        if ((BYPASS != 0) && wr_en && (writeregsel == read1regsel)) begin
            read1data = writedata;
            if (wr_clears) begin
                read1busy = 1'b0;
            end
        end
    end

    always_comb begin
        read2data = regs_q[read2regsel];
        read2busy = busy_q[read2regsel];
        if ((BYPASS != 0) && wr_en && (writeregsel == read2regsel)) begin
            read2data = writedata;
            if (wr_clears) begin
                read2busy = 1'b0;
            end
        end
    end

    always_comb begin
        busycount = '0;
        for (int i = 0; i < NREGS; i++) begin
            busycount = busycount + (AW+1)'(busy_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end
endmodule
